// File: rtl/fetch_ifid_pkg.sv
// Shared constants for the fetch stage: instruction encodings, FSM state
// encodings and small PC/opcode helpers used by fetch_ifid and ifid_reg.
package fetch_ifid_pkg;

    // Encoding injected into IF/ID whenever the stage emits a bubble.
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

    // Opcode field value (bits 15:11) that stops fetching.
    localparam logic [4:0]  OPC_HALT      = 5'b00000;

    // Fetch FSM state encodings.
    localparam logic [1:0]  ST_FETCH      = 2'd0;
    localparam logic [1:0]  ST_DRAIN      = 2'd1;
    localparam logic [1:0]  ST_HALTED     = 2'd2;

    // True when the instruction word carries the HALT opcode.
    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == OPC_HALT;
    endfunction

    // Sequential PC; 16-bit arithmetic so 16'hFFFE wraps to 16'h0000.
    function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_ifid_ifid_reg.sv
// IF/ID pipeline register. Flush loads a bubble (NOP, valid low) and wins
// over hold; hold keeps the current contents; otherwise the new fetch is
// captured. The next-PC field is left untouched by a flush because a bubble
// carries no meaningful PC.
module ifid_reg
    import fetch_ifid_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [15:0] i_instr,
    input  logic [15:0] i_next_pc,
    output logic [15:0] o_instr,
    output logic [15:0] o_next_pc,
    output logic        o_valid
);

    logic [15:0] r_instr;
    logic [15:0] r_next_pc;
    logic        r_valid;

    // Register update: reset to an empty slot, then flush > hold > load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr   <= NOP_INSTR;
            r_next_pc <= 16'h0000;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
        end else if (!i_hold) begin
            r_instr   <= i_instr;
            r_next_pc <= i_next_pc;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_next_pc = r_next_pc;
    assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage with the IF/ID register. Owns the PC and a
// three-state fetch FSM (FETCH / DRAIN / HALTED). A redirect that arrives
// while a memory access is still outstanding parks its target in r_pend_pc
// and waits in DRAIN for the stale word, so the memory never sees the
// address change mid-access.
module fetch_ifid
    import fetch_ifid_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall_id,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [15:0] next_pc_basic,
    output logic        valid_id,
    output logic        err
);

    logic [15:0] r_pc;
    logic [15:0] r_pend_pc;
    logic [1:0]  r_state;

    logic [15:0] w_pc_next;
    logic [15:0] w_pend_next;
    logic [1:0]  w_state_next;
    logic        w_flush;
    logic        w_hold;
    logic [15:0] w_pc_inc;

    assign w_pc_inc = pc_plus2(r_pc);

    // Next-state decode: redirect first, then stall, then per-state fetch.
    always_comb begin
        w_pc_next    = r_pc;
        w_pend_next  = r_pend_pc;
        w_state_next = r_state;
        w_flush      = 1'b0;
        w_hold       = 1'b0;

        if (redirect_en) begin
            // The redirected path starts fresh; whatever sits in IF/ID is wrong-path.
            w_flush = 1'b1;
            if ((r_state == ST_HALTED) || imem_ready) begin
                // Nothing in flight: jump immediately.
                w_pc_next    = redirect_pc;
                w_state_next = ST_FETCH;
            end else begin
                // Access in flight: keep the address stable until it completes.
                w_pend_next  = redirect_pc;
                w_state_next = ST_DRAIN;
            end
        end else if (stall_id) begin
            w_hold = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        w_pc_next = w_pc_inc;
                        if (is_halt(imem_rdata)) begin
                            w_state_next = ST_HALTED;
                        end
                    end else begin
                        w_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The returning word belongs to the abandoned path; drop it.
                    w_flush = 1'b1;
                    if (imem_ready) begin
                        w_pc_next    = r_pend_pc;
                        w_state_next = ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    w_flush = 1'b1;
                end
                default: begin
                    // Unused encoding: bubble and restart fetching.
                    w_flush      = 1'b1;
                    w_state_next = ST_FETCH;
                end
            endcase
        end
    end

    // PC, pending-redirect target and FSM state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_pend_pc <= 16'h0000;
            r_state   <= ST_FETCH;
        end else begin
            r_pc      <= w_pc_next;
            r_pend_pc <= w_pend_next;
            r_state   <= w_state_next;
        end
    end

    // Loads happen only on a consuming FETCH cycle; every other cycle the
    // decode above asserts either hold or flush.
    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .i_hold    (w_hold),
        .i_flush   (w_flush),
        .i_instr   (imem_rdata),
        .i_next_pc (w_pc_inc),
        .o_instr   (instr),
        .o_next_pc (next_pc_basic),
        .o_valid   (valid_id)
    );

    // Request is dropped in HALTED and forced low while reset is held.
    assign imem_req  = rst && (r_state != ST_HALTED);
    assign imem_addr = r_pc;
    assign err       = r_pc[0];

endmodule
